alu_vector_gen: RTL and testbench
=================================

Name: alu_vector_gen

Overview:
- Hardware writer of ALU golden test-vector records, in the same 26-bit record format the ALU fixture reads.
- Generates NUM_VEC stimulus vectors (A, B, ctrl). For each one it computes all four 4-bit signed ALU results and streams the packed record out on a valid/ready port with an address.
- Sits between a vector source and a record memory or checker. It replaces the offline script as the golden-vector producer.

Parameters:
ADDR_W, 4, record address width; the run covers addresses 0..NUM_VEC-1
NUM_VEC, 16, records per run; 1 <= NUM_VEC <= 2^ADDR_W, and NUM_VEC <= 1024
SEED, 8'hA5, LFSR seed, used only when ALU_VEC_LFSR_EN is defined

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run when the FSM is in IDLE
abort  input  1  terminates the run; takes effect on the next edge
rec_ready  input  1  sink accepts rec_data this cycle
rec_valid  output  1  rec_data and rec_addr are valid
rec_data  output  26  {A[25:22], B[21:18], ctrl[17:16], add[15:12], sub[11:8], and[7:4], or[3:0]}
rec_addr  output  ADDR_W  index of the current record
rec_last  output  1  current record is index NUM_VEC-1
busy  output  1  high in GEN state
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rec_valid, rec_last, busy and done are 0.
  - rec_data and rec_addr are 0; the index counter is 0; the LFSR is loaded with SEED.
- FSM states: IDLE, GEN, DONE.
  - IDLE: start=1 -> GEN. Index is cleared to 0 and record 0 is loaded into the output register. rec_valid=1 on the next cycle (latency 1).
  - GEN: a handshake (rec_valid & rec_ready) on index i:
    - if i < NUM_VEC-1: load record i+1 on the same edge, so throughput is 1 record/cycle with rec_ready held high;
    - if i = NUM_VEC-1: rec_valid drops to 0 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Stall: while rec_valid=1 and rec_ready=0, rec_data, rec_addr and rec_last hold stable. The index and LFSR do not advance.
- Stimulus, counter mode (default) for index i:
  - A=i[9:6], B=i[5:2], ctrl=i[1:0], with i zero-extended to 10 bits.
  - NUM_VEC=1024 gives the exhaustive space.
- Results: 4-bit two's complement, wrap-around, no saturation, no flags.
  - add = A+B[3:0]
  - sub = A-B[3:0]
  - and = A&B
  - or = A|B
- Output fields:
  - rec_addr = i[ADDR_W-1:0].
  - rec_last = (i == NUM_VEC-1).
- Simultaneous events and boundaries:
  - start while busy or in DONE: ignored.
  - abort in any state -> IDLE on the next edge. rec_valid=0 and busy=0; done is not pulsed.
  - abort and handshake in the same cycle: the handshake counts for the sink, but the generator still goes to IDLE.
  - abort and start in the same cycle: abort wins.
  - NUM_VEC=1: a single record with rec_last=1, then DONE.
  - Reset mid-run: immediate return to the reset values. A partially delivered record is discarded.

Optional Feature:
- Macro: ALU_VEC_LFSR_EN.
- Defined: operands come from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - A=lfsr[7:4], B=lfsr[3:0]; ctrl remains i[1:0].
  - The LFSR is loaded with SEED on reset and on start. If SEED=0, 8'h01 is loaded instead.
  - The LFSR advances one step per handshake only.
- Undefined: counter mode as in Behaviour. No LFSR logic is present.

Test Plan:
- Reset, counter mode, ADDR_W=4, NUM_VEC=16, rec_ready=1, pulse start -> rec_valid 1 cycle later. Record 0 = 26'h0000000; record 5 (A=0,B=1,ctrl=01) = 0000_0001_01_0001_1111_0000_0001.
- ADDR_W=10, NUM_VEC=1024, run to index 0x1C7 (A=7,B=1,ctrl=11) -> rec_data = 0111_0001_11_1000_0110_0001_0111. This checks that add wraps 7+1 to 1000.
- Toggle rec_ready 1010... and hold it 0 for 5 cycles at record 3 -> rec_data and rec_addr=3 stable throughout. Exactly 16 handshakes, addresses 0..15 with no gaps, rec_last only at 15, a single done pulse after the last handshake.
- Assert abort during the stall at record 7 -> rec_valid=0 and busy=0 next cycle, no done. A subsequent start restarts at rec_addr=0.
- Drop rst_n mid-run at record 9 (asynchronous, between edges) -> all outputs are 0 immediately. A start pulsed while busy is ignored (index unaffected).
- With ALU_VEC_LFSR_EN defined, SEED=8'h00 -> record 0 has A=0000, B=0001, ctrl=00, and the LFSR advances only on handshakes.

Source files
------------

// File: rtl/alu_vector_gen.sv
// alu_vector_gen: hardware producer of 26-bit ALU golden-vector records.
// Each record is {A, B, ctrl, add, sub, and, or} for 4-bit two's-complement
// operands, streamed on a valid/ready port together with its index.
// Optional build macro ALU_VEC_LFSR_EN: operands come from an 8-bit
// Fibonacci LFSR (x^8+x^6+x^5+x^4+1) instead of the index counter.
module alu_vector_gen #(
    parameter int         ADDR_W  = 4,
    parameter int         NUM_VEC = 16,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              rec_ready,
    output logic              rec_valid,
    output logic [25:0]       rec_data,
    output logic [ADDR_W-1:0] rec_addr,
    output logic              rec_last,
    output logic              busy,
    output logic              done
);

    // Index is at least 10 bits wide so the operand fields can always be sliced from it.
    localparam int              IDX_W    = (ADDR_W > 10) ? ADDR_W : 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             hs;
    logic [25:0]      first_rec;
    logic [25:0]      next_rec;

    // Pack one record; add/sub wrap in 4-bit two's complement with no saturation.
    function automatic logic [25:0] pack_rec(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [1:0] ctrl);
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        logic signed [3:0] s_add;
        logic signed [3:0] s_sub;
        sa    = signed'(a);
        sb    = signed'(b);
        s_add = sa + sb;
        s_sub = sa - sb;
        return {a, b, ctrl, $unsigned(s_add), $unsigned(s_sub), a & b, a | b};
    endfunction

    assign hs       = rec_valid & rec_ready;
    assign idx_next = idx + IDX_W'(1);

`ifdef ALU_VEC_LFSR_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr;
    logic [7:0] lfsr_adv;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign lfsr_adv  = lfsr_step(lfsr);
    assign first_rec = pack_rec(SEED_EFF[7:4], SEED_EFF[3:0], 2'b00);
    assign next_rec  = pack_rec(lfsr_adv[7:4], lfsr_adv[3:0], idx_next[1:0]);

    // LFSR holds the operands of the record currently presented; it steps only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else if (!abort) begin
            if (state == S_IDLE && start) begin
                lfsr <= SEED_EFF;
            end else if (state == S_GEN && hs) begin
                lfsr <= lfsr_adv;
            end
        end
    end
`else
    assign first_rec = pack_rec(4'd0, 4'd0, 2'd0);
    assign next_rec  = pack_rec(idx_next[9:6], idx_next[5:2], idx_next[1:0]);
`endif

    // Control FSM plus output record register; abort overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rec_valid <= 1'b0;
            rec_data  <= '0;
            idx       <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            rec_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_GEN;
                        idx       <= '0;
                        rec_data  <= first_rec;
                        rec_valid <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (hs) begin
                        if (idx == LAST_IDX) begin
                            rec_valid <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            idx      <= idx_next;
                            rec_data <= next_rec;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rec_addr = idx[ADDR_W-1:0];
    assign rec_last = rec_valid & (idx == LAST_IDX);
    assign busy     = (state == S_GEN);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_alu_vector_gen.sv
// Directed testbench for alu_vector_gen: three instances cover the
// 16-record default, the 1024-record exhaustive space and NUM_VEC=1.
module tb_alu_vector_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // small instance: ADDR_W=4, NUM_VEC=16
    logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
    logic        s_valid, s_last, s_busy, s_done;
    logic [25:0] s_data;
    logic [3:0]  s_addr;

    // big instance: ADDR_W=10, NUM_VEC=1024
    logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
    logic        b_valid, b_last, b_busy, b_done;
    logic [25:0] b_data;
    logic [9:0]  b_addr;

    // single-record instance: ADDR_W=1, NUM_VEC=1
    logic        o_start = 1'b0, o_abort = 1'b0, o_ready = 1'b0;
    logic        o_valid, o_last, o_busy, o_done;
    logic [25:0] o_data;
    logic [0:0]  o_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt, dn_cnt, stall_cnt, exp_idx;

    always #5 clk = ~clk;

    alu_vector_gen #(.ADDR_W(4), .NUM_VEC(16), .SEED(8'h00)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .rec_ready(s_ready),
        .rec_valid(s_valid), .rec_data(s_data), .rec_addr(s_addr), .rec_last(s_last),
        .busy(s_busy), .done(s_done));

    alu_vector_gen #(.ADDR_W(10), .NUM_VEC(1024), .SEED(8'hA5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .rec_ready(b_ready),
        .rec_valid(b_valid), .rec_data(b_data), .rec_addr(b_addr), .rec_last(b_last),
        .busy(b_busy), .done(b_done));

    alu_vector_gen #(.ADDR_W(1), .NUM_VEC(1), .SEED(8'h5A)) dut_o (
        .clk(clk), .rst_n(rst_n), .start(o_start), .abort(o_abort), .rec_ready(o_ready),
        .rec_valid(o_valid), .rec_data(o_data), .rec_addr(o_addr), .rec_last(o_last),
        .busy(o_busy), .done(o_done));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference record for counter mode, built from the field definitions.
    function automatic logic [25:0] model(input int i);
        logic [9:0] v;
        logic [3:0] a, b, ad, sb;
        logic [1:0] c;
        v  = 10'(i);
        a  = v[9:6];
        b  = v[5:2];
        c  = v[1:0];
        ad = a + b;
        sb = a - b;
        return {a, b, c, ad, sb, a & b, a | b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values ----
        #12;
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_data",  32'(s_data),  32'd0);
        chk("rst_addr",  32'(s_addr),  32'd0);
        chk("rst_last",  32'(s_last),  32'd0);
        chk("rst_busy",  32'(s_busy),  32'd0);
        chk("rst_done",  32'(s_done),  32'd0);
        chk("rst_o_last", 32'(o_last), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- latency 1, record 0 and record 5 ----
        s_ready = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("t1_valid", 32'(s_valid), 32'd1);
        chk("t1_busy",  32'(s_busy),  32'd1);
        chk("t1_addr0", 32'(s_addr),  32'd0);
`ifdef ALU_VEC_LFSR_EN
        chk("t1_data0_lfsr", 32'(s_data), 32'h0041F01);
`else
        chk("t1_data0", 32'(s_data), 32'h0000000);
`endif
        repeat (5) step();
        chk("t1_addr5", 32'(s_addr), 32'd5);
`ifndef ALU_VEC_LFSR_EN
        chk("t1_data5", 32'(s_data), 32'h0051F01);
`endif
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        chk("t1_abort_valid", 32'(s_valid), 32'd0);
        chk("t1_abort_busy",  32'(s_busy),  32'd0);
        chk("t1_abort_done",  32'(s_done),  32'd0);

        // ---- toggled ready, 5-cycle stall at record 3, full run ----
        hs_cnt = 0; dn_cnt = 0; stall_cnt = 0; exp_idx = 0;
        s_ready = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (s_done) dn_cnt++;
            if (s_valid) begin
                chk("t3_addr", 32'(s_addr), 32'(exp_idx));
                chk("t3_last", 32'(s_last), 32'(exp_idx == 15));
`ifndef ALU_VEC_LFSR_EN
                chk("t3_data", 32'(s_data), 32'(model(exp_idx)));
`endif
            end
            if (s_valid && s_addr == 4'd3 && stall_cnt < 5) begin
                s_ready = 1'b0;
                stall_cnt++;
            end else begin
                s_ready = (c % 2 == 0);
            end
            if (s_valid && s_ready) begin
                hs_cnt++;
                exp_idx++;
            end
            step();
        end
        chk("t3_handshakes", 32'(hs_cnt), 32'd16);
        chk("t3_done_pulses", 32'(dn_cnt), 32'd1);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("t3_end_busy", 32'(s_busy), 32'd0);

        // ---- abort during stall at record 7, then restart ----
        s_ready = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 0; c < 20 && s_addr != 4'd7; c++) step();
        s_ready = 1'b0;
        chk("t4_at7_addr", 32'(s_addr), 32'd7);
        step();
        chk("t4_stall_addr",  32'(s_addr),  32'd7);
        chk("t4_stall_valid", 32'(s_valid), 32'd1);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
        chk("t4_abort_valid", 32'(s_valid), 32'd0);
        chk("t4_abort_busy",  32'(s_busy),  32'd0);
        chk("t4_abort_done",  32'(s_done),  32'd0);
        step();
        chk("t4_no_done", 32'(s_done), 32'd0);
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("t4_restart_valid", 32'(s_valid), 32'd1);
        chk("t4_restart_addr",  32'(s_addr),  32'd0);
        s_abort = 1'b1;
        step();
        // abort and start together in IDLE: abort wins
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_abort = 1'b0;
        chk("t4_abort_start_valid", 32'(s_valid), 32'd0);
        chk("t4_abort_start_busy",  32'(s_busy),  32'd0);

        // ---- start while busy ignored, async reset at record 9 ----
        s_ready = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int c = 0; c < 20 && s_addr != 4'd4; c++) step();
        s_ready = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("t5_busy_start_addr",  32'(s_addr),  32'd4);
        chk("t5_busy_start_valid", 32'(s_valid), 32'd1);
        s_ready = 1'b1;
        for (int c = 0; c < 20 && s_addr != 4'd9; c++) step();
        s_ready = 1'b0;
        chk("t5_at9_addr", 32'(s_addr), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(s_valid), 32'd0);
        chk("t5_rst_data",  32'(s_data),  32'd0);
        chk("t5_rst_addr",  32'(s_addr),  32'd0);
        chk("t5_rst_last",  32'(s_last),  32'd0);
        chk("t5_rst_busy",  32'(s_busy),  32'd0);
        chk("t5_rst_done",  32'(s_done),  32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("t5_post_rst_valid", 32'(s_valid), 32'd0);

        // ---- exhaustive space: record 0x1C7 wraps add, then run to end ----
        b_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        repeat (455) step();
        chk("t2_addr_1c7", 32'(b_addr), 32'h1C7);
        chk("t2_last_1c7", 32'(b_last), 32'd0);
`ifndef ALU_VEC_LFSR_EN
        chk("t2_data_1c7", 32'(b_data), 32'h1C78617);
`endif
        for (int c = 0; c < 700 && !b_last; c++) step();
        chk("t2_last", 32'(b_last), 32'd1);
        chk("t2_last_addr", 32'(b_addr), 32'd1023);
`ifndef ALU_VEC_LFSR_EN
        chk("t2_last_data", 32'(b_data), 32'(model(1023)));
`endif
        step();
        chk("t2_done", 32'(b_done), 32'd1);
        chk("t2_done_valid", 32'(b_valid), 32'd0);
        step();
        chk("t2_done_once", 32'(b_done), 32'd0);

        // ---- NUM_VEC=1 ----
        o_ready = 1'b1;
        o_start = 1'b1;
        step();
        o_start = 1'b0;
        chk("t6_valid", 32'(o_valid), 32'd1);
        chk("t6_last",  32'(o_last),  32'd1);
        chk("t6_addr",  32'(o_addr),  32'd0);
`ifndef ALU_VEC_LFSR_EN
        chk("t6_data",  32'(o_data),  32'd0);
`endif
        step();
        chk("t6_done",  32'(o_done),  32'd1);
        chk("t6_after_valid", 32'(o_valid), 32'd0);
        step();
        chk("t6_done_once", 32'(o_done), 32'd0);
        chk("t6_idle_busy", 32'(o_busy), 32'd0);

`ifdef ALU_VEC_LFSR_EN
        // ---- LFSR mode, SEED=0: record 0 from 8'h01, advances only on handshake ----
        s_ready = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("t7_lfsr_rec0", 32'(s_data), 32'h0041F01);
        repeat (3) step();
        chk("t7_lfsr_stall", 32'(s_data), 32'h0041F01);
        s_ready = 1'b1;
        step();
        s_ready = 1'b0;
        chk("t7_lfsr_rec1", 32'(s_data), 32'h0092E02);
        chk("t7_lfsr_addr1", 32'(s_addr), 32'd1);
        s_abort = 1'b1;
        step();
        s_abort = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
